// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage RV32 pipeline: req/ack data-memory port, load extension, stall and WB registers.
// Optional build macro MISALIGN_TRAP_EN: misaligned H/W accesses are trapped instead of issued.
module mem_access_stage #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC_in,
    input  logic [31:0] aluResult_in,
    input  logic [31:0] data2_in,
    input  logic [4:0]  rd_in,
    input  logic [2:0]  funct3_in,
    input  logic        Branch_in,
    input  logic        zero_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic        MemtoReg_in,
    input  logic        RegWrite_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall,
    output logic        PCSrc,
    output logic [31:0] PC_branch,
    output logic [31:0] wb_readData,
    output logic [31:0] wb_aluResult,
    output logic [4:0]  wb_rd,
    output logic        wb_MemtoReg,
    output logic        wb_RegWrite,
    output logic        bus_err,
    output logic        misalign
);

    localparam logic [7:0] TMO = 8'(ACK_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [4:0]  rd_q, rd_d;
    logic        m2r_q, m2r_d;
    logic        rw_q, rw_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] wb_rdata_q, wb_rdata_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic        wb_m2r_q, wb_m2r_d;
    logic        wb_rw_q, wb_rw_d;

    logic        mem_op;
    logic        mis;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'b0, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'b0, h};
            default: load_ext = w;
        endcase
    endfunction

    assign mem_op = MemRead_in | MemWrite_in;

    // funct3[1:0]: 00 byte, 01 half, anything else (incl. illegal codes) word
    always_comb begin
        case (funct3_in[1:0])
            2'b00: begin
                be_new    = 4'b0001 << aluResult_in[1:0];
                wdata_new = {4{data2_in[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << {aluResult_in[1], 1'b0};
                wdata_new = {2{data2_in[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = data2_in;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign mis = mem_op &
                 (((funct3_in[1:0] == 2'b01) & aluResult_in[0]) |
                  (funct3_in[1] & (aluResult_in[1:0] != 2'b00)));
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        m2r_d      = m2r_q;
        rw_d       = rw_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        wb_rdata_d = wb_rdata_q;
        wb_alu_d   = wb_alu_q;
        wb_rd_d    = wb_rd_q;
        wb_m2r_d   = wb_m2r_q;
        wb_rw_d    = wb_rw_q;
        stall      = 1'b0;
        dmem_req   = 1'b0;
        bus_err    = 1'b0;
        misalign   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_op && !mis) begin
                    stall   = 1'b1;
                    addr_d  = aluResult_in;
                    wdata_d = wdata_new;
                    be_d    = be_new;
                    we_d    = MemWrite_in;
                    f3_d    = funct3_in;
                    rd_d    = rd_in;
                    m2r_d   = MemtoReg_in;
                    rw_d    = RegWrite_in;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    cnt_d   = '0;
                    wb_rw_d = 1'b0;
                    state_d = S_WAIT;
                end else begin
                    misalign   = mis;
                    wb_rdata_d = '0;
                    wb_alu_d   = aluResult_in;
                    wb_rd_d    = rd_in;
                    wb_m2r_d   = MemtoReg_in;
                    wb_rw_d    = RegWrite_in & ~mis;
                end
            end
            S_WAIT: begin
                stall   = 1'b1;
                wb_rw_d = 1'b0;
                // Abort cycle: request already withdrawn, so a late ack is ignored
                if (cnt_q == TMO) begin
                    bus_err = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        rdata_d = load_ext(f3_q, addr_q[1:0], dmem_rdata);
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                wb_rdata_d = rdata_q;
                wb_alu_d   = addr_q;
                wb_rd_d    = rd_q;
                wb_m2r_d   = m2r_q;
                wb_rw_d    = rw_q & ~we_q & ~err_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            f3_q       <= '0;
            rd_q       <= '0;
            m2r_q      <= 1'b0;
            rw_q       <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            wb_rdata_q <= '0;
            wb_alu_q   <= '0;
            wb_rd_q    <= '0;
            wb_m2r_q   <= 1'b0;
            wb_rw_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            m2r_q      <= m2r_d;
            rw_q       <= rw_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            wb_rdata_q <= wb_rdata_d;
            wb_alu_q   <= wb_alu_d;
            wb_rd_q    <= wb_rd_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_rw_q    <= wb_rw_d;
        end
    end

    assign dmem_we      = dmem_req & we_q;
    assign dmem_addr    = {addr_q[31:2], 2'b00};
    assign dmem_wdata   = wdata_q;
    assign dmem_be      = be_q;
    assign PCSrc        = Branch_in & zero_in & ~stall;
    assign PC_branch    = PC_in;
    assign wb_readData  = wb_rdata_q;
    assign wb_aluResult = wb_alu_q;
    assign wb_rd        = wb_rd_q;
    assign wb_MemtoReg  = wb_m2r_q;
    assign wb_RegWrite  = wb_rw_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, loads/stores, timeout, reset in WAIT, misalignment.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] PC_in, aluResult_in, data2_in, dmem_rdata;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic        Branch_in, zero_in, MemRead_in, MemWrite_in, MemtoReg_in, RegWrite_in, dmem_ack;
    logic        dmem_req, dmem_we, stall, PCSrc, wb_MemtoReg, wb_RegWrite, bus_err, misalign;
    logic [31:0] dmem_addr, dmem_wdata, PC_branch, wb_readData, wb_aluResult;
    logic [3:0]  dmem_be;
    logic [4:0]  wb_rd;

    int unsigned checks = 0;
    int unsigned errs   = 0;
    int          err_at;
    logic        req_at_err, stall_at_err;

    always #5 clk = ~clk;

    mem_access_stage #(.ACK_TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .PC_in(PC_in), .aluResult_in(aluResult_in),
        .data2_in(data2_in), .rd_in(rd_in), .funct3_in(funct3_in),
        .Branch_in(Branch_in), .zero_in(zero_in), .MemRead_in(MemRead_in),
        .MemWrite_in(MemWrite_in), .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .stall(stall), .PCSrc(PCSrc), .PC_branch(PC_branch),
        .wb_readData(wb_readData), .wb_aluResult(wb_aluResult), .wb_rd(wb_rd),
        .wb_MemtoReg(wb_MemtoReg), .wb_RegWrite(wb_RegWrite),
        .bus_err(bus_err), .misalign(misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        PC_in = '0; aluResult_in = '0; data2_in = '0; rd_in = '0; funct3_in = '0;
        Branch_in = 0; zero_in = 0; MemRead_in = 0; MemWrite_in = 0;
        MemtoReg_in = 0; RegWrite_in = 0; dmem_ack = 0; dmem_rdata = '0;
    endtask

    // Load acked in the first WAIT cycle; checks the extended WB value
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] word, input logic [31:0] exp);
        MemRead_in = 1; RegWrite_in = 1; MemtoReg_in = 1; rd_in = 5'd9;
        funct3_in = f3; aluResult_in = addr;
        @(negedge clk);
        dmem_ack = 1; dmem_rdata = word;
        @(negedge clk);
        dmem_ack = 0; dmem_rdata = '0;
        @(negedge clk);
        chk(tag, wb_readData, exp);
        clr();
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                            input logic [31:0] data, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd);
        MemWrite_in = 1; RegWrite_in = 1; rd_in = 5'd6;
        funct3_in = f3; aluResult_in = addr; data2_in = data;
        @(negedge clk);
        #1;
        chk({tag, "_be"}, {28'b0, dmem_be}, {28'b0, exp_be});
        chk({tag, "_wdata"}, dmem_wdata, exp_wd);
        chk({tag, "_we"}, {31'b0, dmem_we}, 32'd1);
        chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        dmem_ack = 1;
        @(negedge clk);
        dmem_ack = 0;
        @(negedge clk);
        chk({tag, "_wb_rw"}, {31'b0, wb_RegWrite}, 32'd0);
        clr();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; clr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_we", {31'b0, dmem_we}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_wb_rdata", wb_readData, 32'd0);
        chk("rst_wb_alu", wb_aluResult, 32'd0);
        chk("rst_wb_rw", {31'b0, wb_RegWrite}, 32'd0);
        chk("rst_bus_err", {31'b0, bus_err}, 32'd0);
        reset = 0;

        // ALU op with a branch and a stray ack
        aluResult_in = 32'h1234; rd_in = 5; RegWrite_in = 1;
        Branch_in = 1; zero_in = 1; PC_in = 32'h400; dmem_ack = 1; dmem_rdata = '1;
        #1;
        chk("alu_stall", {31'b0, stall}, 32'd0);
        chk("alu_pcsrc", {31'b0, PCSrc}, 32'd1);
        chk("alu_pcbr", PC_branch, 32'h400);
        @(negedge clk);
        chk("alu_wb_alu", wb_aluResult, 32'h1234);
        chk("alu_wb_rd", {27'b0, wb_rd}, 32'd5);
        chk("alu_wb_rw", {31'b0, wb_RegWrite}, 32'd1);
        chk("alu_wb_rdata", wb_readData, 32'd0);
        clr();

        // LB 0x103, ack in the second WAIT cycle
        aluResult_in = 32'h103; rd_in = 7; RegWrite_in = 1; MemtoReg_in = 1;
        MemRead_in = 1; funct3_in = 3'b000; Branch_in = 1; zero_in = 1;
        #1;
        chk("lb_issue_stall", {31'b0, stall}, 32'd1);
        chk("lb_issue_pcsrc", {31'b0, PCSrc}, 32'd0);
        chk("lb_issue_req", {31'b0, dmem_req}, 32'd0);
        @(negedge clk); #1;
        chk("lb_w1_stall", {31'b0, stall}, 32'd1);
        chk("lb_w1_req", {31'b0, dmem_req}, 32'd1);
        chk("lb_w1_addr", dmem_addr, 32'h100);
        chk("lb_w1_we", {31'b0, dmem_we}, 32'd0);
        chk("lb_w1_bubble", {31'b0, wb_RegWrite}, 32'd0);
        @(negedge clk);
        dmem_ack = 1; dmem_rdata = 32'h80FF_0000;
        #1;
        chk("lb_w2_stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        dmem_ack = 0; dmem_rdata = '0;
        #1;
        chk("lb_done_stall", {31'b0, stall}, 32'd0);
        chk("lb_done_req", {31'b0, dmem_req}, 32'd0);
        chk("lb_done_pcsrc", {31'b0, PCSrc}, 32'd1);
        @(negedge clk);
        chk("lb_wb_rdata", wb_readData, 32'hFFFF_FF80);
        chk("lb_wb_rd", {27'b0, wb_rd}, 32'd7);
        chk("lb_wb_rw", {31'b0, wb_RegWrite}, 32'd1);
        chk("lb_wb_m2r", {31'b0, wb_MemtoReg}, 32'd1);
        chk("lb_wb_alu", wb_aluResult, 32'h103);
        clr();

        do_load("lh_neg", 32'h102, 3'b001, 32'h80FF_0000, 32'hFFFF_80FF);
        do_load("lhu", 32'h102, 3'b101, 32'h80FF_0000, 32'h0000_80FF);
        do_load("lh_lo", 32'h100, 3'b001, 32'h0000_8001, 32'hFFFF_8001);
        do_load("lbu", 32'h100, 3'b100, 32'h0000_00F0, 32'h0000_00F0);
        do_load("lb_pos", 32'h101, 3'b000, 32'h0000_7F00, 32'h0000_007F);
        do_load("lw", 32'h108, 3'b010, 32'h1234_5678, 32'h1234_5678);
        do_load("illegal_f3", 32'h400, 3'b011, 32'h8000_0001, 32'h8000_0001);

        do_store("sh", 32'h102, 3'b001, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD);
        do_store("sb", 32'h101, 3'b000, 32'h1234_565A, 4'b0010, 32'h5A5A_5A5A);
        do_store("sw", 32'h10C, 3'b010, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        // Timeout: LW never acked
        aluResult_in = 32'h200; rd_in = 3; RegWrite_in = 1; MemRead_in = 1; funct3_in = 3'b010;
        err_at = -1; req_at_err = 1'bx; stall_at_err = 1'bx;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (bus_err === 1'b1) begin
                err_at = i; req_at_err = dmem_req; stall_at_err = stall;
                break;
            end
            @(negedge clk);
        end
        chk("tmo_cycle", 32'(err_at), 32'd256);
        chk("tmo_req", {31'b0, req_at_err}, 32'd0);
        chk("tmo_stall", {31'b0, stall_at_err}, 32'd1);
        @(negedge clk); #1;
        chk("tmo_after_stall", {31'b0, stall}, 32'd0);
        chk("tmo_after_err", {31'b0, bus_err}, 32'd0);
        @(negedge clk);
        chk("tmo_wb_rw", {31'b0, wb_RegWrite}, 32'd0);
        chk("tmo_wb_alu", wb_aluResult, 32'h200);
        clr();

        // Reset in WAIT followed by a stray ack
        aluResult_in = 32'h300; rd_in = 4; RegWrite_in = 1; MemRead_in = 1; funct3_in = 3'b010;
        @(negedge clk); #1;
        chk("rw_req", {31'b0, dmem_req}, 32'd1);
        reset = 1;
        @(negedge clk);
        reset = 0; clr(); dmem_ack = 1; dmem_rdata = 32'h5555_AAAA;
        #1;
        chk("rw_req_off", {31'b0, dmem_req}, 32'd0);
        chk("rw_stall", {31'b0, stall}, 32'd0);
        chk("rw_wb_alu", wb_aluResult, 32'd0);
        chk("rw_wb_rd", {27'b0, wb_rd}, 32'd0);
        @(negedge clk);
        dmem_ack = 0;
        chk("rw_wb_rdata", wb_readData, 32'd0);
        chk("rw_wb_rw", {31'b0, wb_RegWrite}, 32'd0);
        chk("rw_wb_m2r", {31'b0, wb_MemtoReg}, 32'd0);
        chk("rw_req_idle", {31'b0, dmem_req}, 32'd0);
        clr();

        // Misaligned LW at 0x2
        aluResult_in = 32'h2; rd_in = 8; RegWrite_in = 1; MemRead_in = 1; funct3_in = 3'b010;
`ifdef MISALIGN_TRAP_EN
        #1;
        chk("mis_pulse", {31'b0, misalign}, 32'd1);
        chk("mis_stall", {31'b0, stall}, 32'd0);
        chk("mis_req", {31'b0, dmem_req}, 32'd0);
        @(negedge clk);
        clr();
        #1;
        chk("mis_pulse_end", {31'b0, misalign}, 32'd0);
        chk("mis_req_after", {31'b0, dmem_req}, 32'd0);
        chk("mis_wb_rw", {31'b0, wb_RegWrite}, 32'd0);
`else
        #1;
        chk("mis_flag", {31'b0, misalign}, 32'd0);
        chk("mis_stall", {31'b0, stall}, 32'd1);
        @(negedge clk); #1;
        chk("mis_addr", dmem_addr, 32'h0);
        chk("mis_be", {28'b0, dmem_be}, 32'hF);
        chk("mis_req", {31'b0, dmem_req}, 32'd1);
        dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem_ack = 0; dmem_rdata = '0;
        @(negedge clk);
        chk("mis_wb_rdata", wb_readData, 32'hDEAD_BEEF);
        clr();
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
